aes_cbc_chain_ctrl: RTL and testbench
=====================================

# aes_cbc_chain_ctrl

Sequential CBC controller that drives the combinational AES-128 encryption core and consumes the 128-bit key produced by the SHAKE128 squeeze interface. It fetches a key from the SHAKE squeeze port with a valid/ack handshake and streams a multi-block message through the AES core. Each ciphertext block is fed back as the IV of the next block, and ciphertext is presented on a ready/valid output stream. It replaces the push-button key gating with a proper per-message handshake.

## Interface

- AES_WAIT, 1, cycles AES inputs are held stable before `i_aes_ct` is sampled; legal range 1..15.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start a message; honoured only in IDLE.
- i_rekey  in  1  sampled with `i_start`; 1 forces a new SHAKE key fetch.
- i_iv  in  128  initial IV, latched on accepted `i_start`.
- i_abort  in  1  synchronous abort to IDLE.
- i_shake_data  in  128  SHAKE squeeze output.
- i_shake_valid  in  1  squeeze data valid.
- o_shake_ack  out  1  one-cycle pulse acknowledging a consumed squeeze word.
- i_pt_data  in  128  plaintext block.
- i_pt_valid  in  1  plaintext valid.
- i_pt_last  in  1  marks final block of the message.
- o_pt_ready  out  1  plaintext accept.
- o_aes_pt / o_aes_key / o_aes_iv  out  128 each  registered inputs to the AES core.
- i_aes_ct  in  128  AES core output, equal to E_key(pt XOR iv).
- o_ct_data  out  128  ciphertext block.
- o_ct_valid  out  1  ciphertext valid.
- o_ct_last  out  1  ciphertext is the final block.
- i_ct_ready  in  1  downstream accept.
- o_key_loaded  out  1  key register holds a SHAKE-derived key.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle pulse when the last block is accepted.

## Operation

- FSM states: IDLE, KEY, LOAD, ENC, OUT.
- **IDLE**
  - On `i_start`, latch `i_iv` into the chain register.
  - Go to KEY if `i_rekey=1` or `o_key_loaded=0`; otherwise go to LOAD.
- **KEY**
  - Wait for `i_shake_valid`.
  - On the first cycle it is seen, latch `i_shake_data` into the key register and set `o_key_loaded`.
  - Pulse `o_shake_ack` for exactly the next cycle, then go to LOAD.
  - A valid that stays high after the capture is not consumed again.
- **LOAD**
  - `o_pt_ready=1`.
  - On `i_pt_valid & o_pt_ready`, latch the block and `i_pt_last`, load the wait counter with AES_WAIT, and go to ENC.
- **ENC**
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, capture `i_aes_ct` into both the ct register and the chain register, then go to OUT.
- **OUT**
  - `o_ct_valid=1`, `o_ct_last` = latched last flag.
  - On `i_ct_ready`:
    - if last: pulse `o_done` and go to IDLE;
    - otherwise go to LOAD.
- **AES core drive:** `o_aes_pt`/`o_aes_key`/`o_aes_iv` come from the plaintext, key and chain registers in every state. CBC chaining is therefore `iv(n+1) = ct(n)`.
- **i_abort:** in any state, go to IDLE next cycle.
  - Clears `o_ct_valid`, `o_pt_ready` and the pending ack.
  - Key register and `o_key_loaded` are retained.
  - `i_abort` has priority over every other input.
- **Simultaneous events:**
  - `i_start` outside IDLE is ignored.
  - `i_start` and `i_abort` in the same cycle: abort wins and the start is dropped.
- `o_key_loaded` clears only on reset.

## Timing

- Reset value of every output is 0, including `o_aes_*` and `o_ct_data`. All registers clear and the FSM is in IDLE.
- Start in cycle t, key already loaded: `o_pt_ready` is high in t+1.
- Start with a key fetch: valid seen in cycle k → ack high in k+1 → `o_pt_ready` high in k+1.
- Plaintext accepted in cycle p:
  - ENC occupies p+1 .. p+AES_WAIT;
  - `o_ct_valid` is high from p+AES_WAIT+1 until accepted.
- Sustained throughput with `i_ct_ready=1`: one block per AES_WAIT+2 cycles.
- `o_ct_data`/`o_ct_last` stay stable while `o_ct_valid=1 & i_ct_ready=0`.
- Reset asserted mid-message: all outputs return to reset values asynchronously. The partial message is lost and no `o_done` is produced.

## Test plan

- **Reset:** assert `i_rst_n=0` mid-OUT → all outputs 0 immediately; after release, `o_busy=0` and `o_key_loaded=0`.
- **Key fetch:** start with `i_rekey=1`; SHAKE drives `2b7e151628aed2a6abf7158809cf4f3c`, valid held 5 cycles → exactly one ack pulse, `o_aes_key` equals that value, `o_key_loaded=1`.
- **NIST SP800-38A CBC vector:**
  - IV `000102030405060708090a0b0c0d0e0f`;
  - PT1 `6bc1bee22e409f96e93d7e117393172a` → CT1 `7649abac8119b246cee98e9b12e9197d`;
  - PT2 (last) `ae2d8a571e03ac9c9eb76fac45af8e51` → CT2 `5086cb9b507219ee95db113a917678b2`, `o_ct_last=1`, `o_done` pulse.
- **Backpressure:** hold `i_ct_ready=0` for 7 cycles on CT1 → CT1 stable, `o_pt_ready=0` throughout, CT2 still correct.
- **Key reuse and ignored start:**
  - second message with `i_rekey=0` → no ack, LOAD reached in t+1;
  - `i_start` during ENC ignored.
- **Abort:** abort in ENC → IDLE next cycle, no ct emitted, key retained; restart reproduces CT1.

Source files
------------

// File: rtl/aes_cbc_chain_ctrl.sv
// CBC chaining controller around a combinational AES-128 core: fetches a key from
// the SHAKE squeeze port, then streams plaintext blocks, feeding each ciphertext back as IV.
module aes_cbc_chain_ctrl #(
  parameter int unsigned AES_WAIT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_rekey,
  input  logic [127:0] i_iv,
  input  logic         i_abort,
  input  logic [127:0] i_shake_data,
  input  logic         i_shake_valid,
  output logic         o_shake_ack,
  input  logic [127:0] i_pt_data,
  input  logic         i_pt_valid,
  input  logic         i_pt_last,
  output logic         o_pt_ready,
  output logic [127:0] o_aes_pt,
  output logic [127:0] o_aes_key,
  output logic [127:0] o_aes_iv,
  input  logic [127:0] i_aes_ct,
  output logic [127:0] o_ct_data,
  output logic         o_ct_valid,
  output logic         o_ct_last,
  input  logic         i_ct_ready,
  output logic         o_key_loaded,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_ENC  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [3:0] WAIT_INIT = 4'(AES_WAIT);

  logic [2:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic         key_loaded_q, key_loaded_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] pt_q, pt_d;
  logic         last_q, last_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] ct_q, ct_d;
  logic         ack_q, ack_d;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    chain_d      = chain_q;
    pt_d         = pt_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    ct_d         = ct_q;
    ack_d        = 1'b0;

    // Abort outranks everything, including a start in the same cycle.
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            chain_d = i_iv;
            state_d = (i_rekey || !key_loaded_q) ? S_KEY : S_LOAD;
          end
        end
        S_KEY: begin
          if (i_shake_valid) begin
            key_d        = i_shake_data;
            key_loaded_d = 1'b1;
            ack_d        = 1'b1;
            state_d      = S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_pt_valid) begin
            pt_d    = i_pt_data;
            last_d  = i_pt_last;
            cnt_d   = WAIT_INIT;
            state_d = S_ENC;
          end
        end
        S_ENC: begin
          if (cnt_q <= 4'd1) begin
            ct_d    = i_aes_ct;
            chain_d = i_aes_ct;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_OUT: begin
          if (i_ct_ready) begin
            state_d = last_q ? S_IDLE : S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      chain_q      <= '0;
      pt_q         <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      ct_q         <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      chain_q      <= chain_d;
      pt_q         <= pt_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      ct_q         <= ct_d;
      ack_q        <= ack_d;
    end
  end

  assign o_shake_ack  = ack_q;
  assign o_pt_ready   = (state_q == S_LOAD);
  assign o_aes_pt     = pt_q;
  assign o_aes_key    = key_q;
  assign o_aes_iv     = chain_q;
  assign o_ct_data    = ct_q;
  assign o_ct_valid   = (state_q == S_OUT);
  assign o_ct_last    = (state_q == S_OUT) && last_q;
  assign o_key_loaded = key_loaded_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_OUT) && last_q && i_ct_ready && !i_abort;

endmodule

// File: tb/tb_aes_cbc_chain_ctrl.sv
// Directed bench for aes_cbc_chain_ctrl using the NIST SP800-38A CBC-AES128 vectors;
// the AES core is a lookup stub that knows the two vector blocks.
module tb_aes_cbc_chain_ctrl;

  localparam int unsigned W = 3;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, rekey, abort_i;
  logic [127:0] iv;
  logic [127:0] shake_data;
  logic         shake_valid;
  logic         shake_ack;
  logic [127:0] pt_data;
  logic         pt_valid, pt_last, pt_ready;
  logic [127:0] aes_pt, aes_key, aes_iv, aes_ct;
  logic [127:0] ct_data;
  logic         ct_valid, ct_last, ct_ready;
  logic         key_loaded, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  aes_cbc_chain_ctrl #(.AES_WAIT(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rekey(rekey), .i_iv(iv),
    .i_abort(abort_i), .i_shake_data(shake_data), .i_shake_valid(shake_valid),
    .o_shake_ack(shake_ack), .i_pt_data(pt_data), .i_pt_valid(pt_valid),
    .i_pt_last(pt_last), .o_pt_ready(pt_ready), .o_aes_pt(aes_pt),
    .o_aes_key(aes_key), .o_aes_iv(aes_iv), .i_aes_ct(aes_ct),
    .o_ct_data(ct_data), .o_ct_valid(ct_valid), .o_ct_last(ct_last),
    .i_ct_ready(ct_ready), .o_key_loaded(key_loaded), .o_busy(busy), .o_done(done)
  );

  // Known-answer AES stub; anything off the vector path gets a distinct filler value.
  function automatic logic [127:0] aes_model(input logic [127:0] p, input logic [127:0] k,
                                             input logic [127:0] v);
    logic [127:0] x;
    x = p ^ v;
    if (k == KEY && x == (PT1 ^ IV))  return CT1;
    if (k == KEY && x == (PT2 ^ CT1)) return CT2;
    return x ^ k ^ 128'h5a5a5a5a_00000000_a5a5a5a5_ffffffff;
  endfunction

  always_comb aes_ct = aes_model(aes_pt, aes_key, aes_iv);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".ack"}, shake_ack, 1'b0);
    chk1({tag, ".pt_ready"}, pt_ready, 1'b0);
    chk({tag, ".aes_pt"}, aes_pt, '0);
    chk({tag, ".aes_key"}, aes_key, '0);
    chk({tag, ".aes_iv"}, aes_iv, '0);
    chk({tag, ".ct_data"}, ct_data, '0);
    chk1({tag, ".ct_valid"}, ct_valid, 1'b0);
    chk1({tag, ".ct_last"}, ct_last, 1'b0);
    chk1({tag, ".key_loaded"}, key_loaded, 1'b0);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".done"}, done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rekey = 1'b0; abort_i = 1'b0; iv = '0;
    shake_data = '0; shake_valid = 1'b0; pt_data = '0; pt_valid = 1'b0;
    pt_last = 1'b0; ct_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Key fetch with valid held for five cycles
    start = 1'b1; rekey = 1'b1; iv = IV;
    tick();
    start = 1'b0; rekey = 1'b0;
    chk1("key.busy", busy, 1'b1);
    chk1("key.pt_ready_wait", pt_ready, 1'b0);
    chk1("key.ack_wait", shake_ack, 1'b0);
    shake_data = KEY;
    tick();
    chk1("key.no_ack_without_valid", shake_ack, 1'b0);
    chk1("key.not_loaded_yet", key_loaded, 1'b0);
    shake_valid = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (shake_ack) ack_cnt++;
      if (i == 0) begin
        chk1("key.ack_k1", shake_ack, 1'b1);
        chk1("key.pt_ready_k1", pt_ready, 1'b1);
        chk("key.aes_key", aes_key, KEY);
        chk1("key.loaded", key_loaded, 1'b1);
        chk("key.aes_iv", aes_iv, IV);
      end
    end
    shake_valid = 1'b0;
    tick();
    if (shake_ack) ack_cnt++;
    chk("key.ack_count", 128'(ack_cnt), 128'd1);

    // Block 1, then seven cycles of backpressure while PT2 waits
    pt_data = PT1; pt_valid = 1'b1; pt_last = 1'b0;
    tick();
    pt_valid = 1'b0;
    chk1("enc.pt_ready", pt_ready, 1'b0);
    chk("enc.aes_pt", aes_pt, PT1);
    tick();
    tick();
    chk1("enc.ct_valid_early", ct_valid, 1'b0);
    tick();
    chk1("b1.ct_valid", ct_valid, 1'b1);
    chk("b1.aes_iv_chained", aes_iv, CT1);
    pt_data = PT2; pt_valid = 1'b1; pt_last = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk1("bp.ct_valid", ct_valid, 1'b1);
      chk("bp.ct_data", ct_data, CT1);
      chk1("bp.ct_last", ct_last, 1'b0);
      chk1("bp.pt_ready", pt_ready, 1'b0);
      tick();
    end
    ct_ready = 1'b1;
    #1;
    chk1("b1.no_done", done, 1'b0);
    tick();
    ct_ready = 1'b0;
    chk1("b2.pt_ready", pt_ready, 1'b1);
    chk1("b2.ct_valid_low", ct_valid, 1'b0);
    tick();
    pt_valid = 1'b0; pt_last = 1'b0;
    chk("b2.aes_pt", aes_pt, PT2);
    tick();
    tick();
    tick();
    chk1("b2.ct_valid", ct_valid, 1'b1);
    chk("b2.ct_data", ct_data, CT2);
    chk1("b2.ct_last", ct_last, 1'b1);
    chk1("b2.done_before_ready", done, 1'b0);
    ct_ready = 1'b1;
    #1;
    chk1("b2.done", done, 1'b1);
    tick();
    ct_ready = 1'b0;
    chk1("end.done_pulse", done, 1'b0);
    chk1("end.busy", busy, 1'b0);
    chk1("end.key_loaded", key_loaded, 1'b1);

    // Key reuse; a start during ENC is ignored
    start = 1'b1; rekey = 1'b0; iv = IV;
    tick();
    start = 1'b0;
    chk1("reuse.pt_ready_t1", pt_ready, 1'b1);
    chk1("reuse.no_ack", shake_ack, 1'b0);
    chk("reuse.aes_iv", aes_iv, IV);
    pt_data = PT1; pt_valid = 1'b1; pt_last = 1'b0;
    tick();
    pt_valid = 1'b0;
    start = 1'b1; rekey = 1'b1; iv = 128'hffff;
    tick();
    start = 1'b0; rekey = 1'b0;
    chk("ign.aes_iv", aes_iv, IV);
    chk1("ign.ack", shake_ack, 1'b0);
    tick();
    tick();
    chk1("reuse.ct_valid", ct_valid, 1'b1);
    chk("reuse.ct_data", ct_data, CT1);
    chk1("reuse.ack_out", shake_ack, 1'b0);
    ct_ready = 1'b1;
    tick();
    ct_ready = 1'b0;
    chk1("reuse.load2", pt_ready, 1'b1);

    // Abort in ENC together with a start
    pt_data = PT2; pt_valid = 1'b1; pt_last = 1'b1;
    tick();
    pt_valid = 1'b0;
    abort_i = 1'b1; start = 1'b1; iv = IV;
    tick();
    abort_i = 1'b0; start = 1'b0;
    chk1("abort.busy", busy, 1'b0);
    chk1("abort.pt_ready", pt_ready, 1'b0);
    chk1("abort.key_loaded", key_loaded, 1'b1);
    chk("abort.aes_key", aes_key, KEY);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("abort.no_ct", ct_valid, 1'b0);
    end
    abort_i = 1'b1; start = 1'b1;
    tick();
    abort_i = 1'b0; start = 1'b0;
    chk1("abort_start.idle", busy, 1'b0);

    // Restart reproduces CT1, then reset mid-OUT
    start = 1'b1; iv = IV;
    tick();
    start = 1'b0;
    chk1("restart.pt_ready", pt_ready, 1'b1);
    pt_data = PT1; pt_valid = 1'b1; pt_last = 1'b0;
    tick();
    pt_valid = 1'b0;
    tick();
    tick();
    tick();
    chk1("restart.ct_valid", ct_valid, 1'b1);
    chk("restart.ct_data", ct_data, CT1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    chk1("post_reset.busy", busy, 1'b0);
    chk1("post_reset.key_loaded", key_loaded, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
